sll_seq: RTL and testbench

Multi-cycle 32-bit logical left shifter for the ALU. It is the left-shift counterpart of the combinational arithmetic right shifter: zero fill from the LSB instead of sign fill from the MSB. It applies one binary-weighted shift stage per clock cycle, so a single 32-bit stage register replaces a five-level mux tree. It sits beside the adder and logic units and uses a start/busy/done handshake toward the ALU sequencer.

---
 rtl/sll_seq.sv | 99 +++++++++
 tb/tb_sll_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sll_seq.sv
// sll_seq: multi-cycle 32-bit logical left shifter applying one binary-weighted stage per clock.
// Optional macro SLL_SEQ_EARLY_EXIT_EN finishes as soon as no higher amount bits remain.
module sll_seq (
   input  logic        clock,
   input  logic        resetn,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [4:0]  amt,
   output logic        busy,
   output logic        done,
   output logic [31:0] out
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] sreg_q, sreg_d;
   logic [4:0]  areg_q, areg_d;
   logic [2:0]  stage_q, stage_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] out_q, out_d;

   logic [4:0]  step;
   logic [31:0] shifted;
   logic        last_stage;
`ifdef SLL_SEQ_EARLY_EXIT_EN
   logic [4:0]  above;
`endif

   always_comb begin
      step    = 5'd1 << stage_q;
      shifted = areg_q[stage_q] ? (sreg_q << step) : sreg_q;
`ifdef SLL_SEQ_EARLY_EXIT_EN
      // Done once no amount bits remain above the current stage.
      above      = areg_q >> stage_q;
      last_stage = (stage_q == 3'd4) || ((above >> 1) == 5'd0);
`else
      last_stage = (stage_q == 3'd4);
`endif
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      areg_d  = areg_q;
      stage_d = stage_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      out_d   = out_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sreg_d  = a;
               areg_d  = amt;
               stage_d = 3'd0;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         default: begin
            sreg_d  = shifted;
            stage_d = stage_q + 3'd1;
            if (last_stage) begin
               out_d   = shifted;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         sreg_q  <= 32'h0;
         areg_q  <= 5'd0;
         stage_q <= 3'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         areg_q  <= areg_d;
         stage_q <= stage_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out_q   <= out_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign out  = out_q;

endmodule

// File: tb/tb_sll_seq.sv
// Self-checking bench for sll_seq: directed cases plus random operands against an arithmetic model.
module tb_sll_seq;

   logic        clock;
   logic        resetn;
   logic        start;
   logic [31:0] a;
   logic [4:0]  amt;
   logic        busy;
   logic        done;
   logic [31:0] out;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_out = 32'h0;

`ifdef SLL_SEQ_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   sll_seq dut (
      .clock  (clock),
      .resetn (resetn),
      .start  (start),
      .a      (a),
      .amt    (amt),
      .busy   (busy),
      .done   (done),
      .out    (out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Cycles from accept edge to done: highest set bit + 1 when exiting early, else always 5.
   function automatic int latency(input logic [4:0] sv);
      int l;
      if (!EARLY) return 5;
      l = 1;
      for (int i = 0; i < 5; i++)
         if (sv[i]) l = i + 1;
      return l;
   endfunction

   task automatic issue(input logic [31:0] av, input logic [4:0] sv);
      a     = av;
      amt   = sv;
      start = 1'b1;
   endtask

   // Called at a negedge with the request already driven; returns at the negedge of the done cycle.
   task automatic track(input logic [31:0] av, input logic [4:0] sv, input bit hold,
                        input int junk_k, input string tag);
      logic [31:0] expv;
      int lat;
      expv = 32'(64'(av) * (64'd1 << sv));
      lat  = latency(sv);
      @(posedge clock);
      @(negedge clock);
      if (!hold) start = 1'b0;
      for (int k = 0; k < lat; k++) begin
         if (k == junk_k) begin
            start = 1'b1;
            a     = 32'hFFFF_FFFF;
            amt   = 5'd0;
         end else if (k == junk_k + 1) begin
            start = 1'b0;
         end
         chk({tag, " busy"}, 32'(busy), 32'd1);
         chk({tag, " early done"}, 32'(done), 32'd0);
         chk({tag, " out held"}, out, model_out);
         @(negedge clock);
      end
      if (!hold) start = 1'b0;
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " busy at done"}, 32'(busy), 32'd0);
      chk({tag, " result"}, out, expv);
      model_out = expv;
      $display("op %s: a=%h amt=%0d out=%h expected=%h latency=%0d", tag, av, sv, out, expv, lat);
   endtask

   task automatic quiet(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         chk({tag, " no done"}, 32'(done), 32'd0);
         chk({tag, " idle busy"}, 32'(busy), 32'd0);
         chk({tag, " out stable"}, out, model_out);
      end
   endtask

   initial begin
      logic [31:0] ra;
      logic [4:0]  rs;
      resetn = 1'b0;
      start  = 1'b0;
      a      = 32'h0;
      amt    = 5'd0;
      #12;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset out", out, 32'h0);
      @(negedge clock);
      resetn = 1'b1;
      quiet(2, "post reset");

      issue(32'h0000_0001, 5'd31);
      track(32'h0000_0001, 5'd31, 1'b0, -1, "msb");
      quiet(2, "msb after");

      issue(32'hFFFF_FFFF, 5'd4);
      track(32'hFFFF_FFFF, 5'd4, 1'b0, -1, "zero fill");
      quiet(1, "zero fill after");

      issue(32'h8000_0001, 5'd1);
      track(32'h8000_0001, 5'd1, 1'b0, -1, "msb discard");
      quiet(1, "msb discard after");

      issue(32'hDEAD_BEEF, 5'd0);
      track(32'hDEAD_BEEF, 5'd0, 1'b0, -1, "zero shift");
      quiet(1, "zero shift after");

      issue(32'h0000_0001, 5'd3);
      track(32'h0000_0001, 5'd3, 1'b0, 1, "start busy");
      quiet(6, "start busy after");

      issue(32'h0000_0003, 5'd5);
      track(32'h0000_0003, 5'd5, 1'b1, -1, "b2b first");
      issue(32'h0000_00FF, 5'd8);
      track(32'h0000_00FF, 5'd8, 1'b0, -1, "b2b second");
      quiet(2, "b2b after");

      // Abort between E2 and E3.
      issue(32'h1234_5678, 5'd16);
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      chk("abort busy", 32'(busy), 32'd1);
      @(posedge clock);
      @(posedge clock);
      #2;
      resetn = 1'b0;
      #1;
      chk("abort busy cleared", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort out", out, 32'h0);
      model_out = 32'h0;
      @(negedge clock);
      resetn = 1'b1;
      quiet(8, "abort after");

      for (int i = 0; i < 25; i++) begin
         ra = $urandom;
         rs = 5'($urandom_range(0, 31));
         issue(ra, rs);
         track(ra, rs, 1'b0, -1, "random");
         quiet(int'($urandom_range(0, 2)), "random gap");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
